instr_fetch_unit: RTL and testbench

//   Fetch stage that sits directly upstream of the CPU core and feeds it instructions.
//   - Drives iaddr to instruction memory through a req/gnt/rvalid interface.
//   - Buffers returned words in a small prefetch FIFO.
//   - Presents {instr, pc} to decode over a valid/ready handshake.
//   - Handles control-flow redirects by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_unit                                                 |
// | Brief   : Fetch stage with prefetch FIFO, in-order imem req/gnt/rvalid     |
// |           interface, redirect flush and stale-response discard.            |
// |           Optional perf counters under `IFU_PERF_CNT_EN.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] iaddr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_head_pc;
  logic [31:0]        r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] r_outstanding;
  logic [c_CNT_W-1:0] r_discard_cnt;

  logic               w_issue;
  logic               w_rsp;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic [c_CNT_W:0]   w_credit_used;
  logic [c_CNT_W-1:0] w_live;
  logic [c_CNT_W-1:0] w_inc;
  logic [c_CNT_W-1:0] w_dec;
  logic [c_CNT_W-1:0] w_push_c;
  logic [c_CNT_W-1:0] w_pop_c;
  logic [31:0]        w_target;

  // Outstanding counts every in-flight request, stale or not, so it caps total credit.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};
  assign imem_req      = reset & ~redirect_valid & (w_credit_used < c_DEPTH);
  assign w_issue       = imem_req & imem_gnt;
  assign w_rsp         = imem_rvalid & (r_outstanding != '0);
  assign w_drop        = w_rsp & (r_discard_cnt != '0);
  assign w_push        = w_rsp & ~w_drop & ~redirect_valid;
  assign if_valid      = reset & (r_count != '0);
  assign w_pop         = if_valid & if_ready & ~redirect_valid;
  assign w_live        = r_outstanding - r_discard_cnt;
  assign w_target      = {redirect_pc[31:2], 2'b00};

  assign w_inc    = {{(c_CNT_W-1){1'b0}}, w_issue};
  assign w_dec    = {{(c_CNT_W-1){1'b0}}, w_rsp};
  assign w_push_c = {{(c_CNT_W-1){1'b0}}, w_push};
  assign w_pop_c  = {{(c_CNT_W-1){1'b0}}, w_pop};

  assign iaddr    = reset ? r_fetch_pc : RESET_PC;
  assign pc       = reset ? r_head_pc : RESET_PC;
  assign if_instr = if_valid ? r_fifo[r_rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_head_pc     <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else begin
      r_outstanding <= r_outstanding + w_inc - w_dec;
      if (redirect_valid) begin
        r_fetch_pc    <= w_target;
        r_head_pc     <= w_target;
        r_rd_ptr      <= '0;
        r_wr_ptr      <= '0;
        r_count       <= '0;
        // Every live request still in flight becomes stale; a same-cycle response retires one.
        r_discard_cnt <= r_discard_cnt + w_live - w_dec;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)  r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + c_PTR_W'(1);
          r_head_pc <= r_head_pc + 32'd4;
        end
        r_count <= r_count + w_push_c - w_pop_c;
        if (w_drop) r_discard_cnt <= r_discard_cnt - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= idata;
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!if_valid && !redirect_valid && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (redirect_valid && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign fetch_stall_cnt = r_stall_cnt;
  assign flush_cnt       = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_instr_fetch_unit                                              |
// | Brief   : Self-checking bench for instr_fetch_unit with an in-order memory |
// |           responder and a sequential-stream reference model.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] iaddr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt;
  logic [31:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .iaddr          (iaddr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .pc             (pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_stall_cnt(fetch_stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  int cmp_n = 0;
  int err_n = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t pend_q[$];
  int   cyc = 0;
  int   gnt_pct = 100;
  int   rv_pct = 100;
  int   max_lat = 1;
  bit   rsp_en = 1'b1;
  bit   inject_junk = 1'b0;

  logic        s_req, s_gnt_hs, s_valid, s_hs;
  logic [31:0] s_iaddr, s_pc, s_instr;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: memory drives its inputs, outputs are sampled mid-cycle, then the edge passes.
  task automatic tick();
    req_t r;
    if (!reset) pend_q.delete();
    imem_rvalid = 1'b0;
    idata       = $urandom;
    if (inject_junk) begin
      imem_rvalid = 1'b1;
      idata       = 32'hDEAD_BEEF;
    end else if (rsp_en && pend_q.size() > 0 && pend_q[0].due <= cyc &&
                 $urandom_range(0, 99) < rv_pct) begin
      imem_rvalid = 1'b1;
      idata       = memw(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    #1;
    s_req    = imem_req;
    s_iaddr  = iaddr;
    s_valid  = if_valid;
    s_pc     = pc;
    s_instr  = if_instr;
    s_gnt_hs = imem_req & imem_gnt;
    s_hs     = if_valid & if_ready & ~redirect_valid;
    if (s_gnt_hs) begin
      r.addr = iaddr;
      r.due  = cyc + $urandom_range(1, max_lat);
      pend_q.push_back(r);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    gnt_pct = 100; rv_pct = 100; max_lat = 1; rsp_en = 1'b1;
    repeat (2) tick();
    cmp_n++; if (s_req !== 1'b0) begin err_n++; $display("FAIL reset_req: got %b want 0", s_req); end
    cmp_n++; if (s_valid !== 1'b0) begin err_n++; $display("FAIL reset_valid: got %b want 0", s_valid); end
    cmp_n++; if (s_iaddr !== 32'h0) begin err_n++; $display("FAIL reset_iaddr: got %h want 0", s_iaddr); end
    cmp_n++; if (s_pc !== 32'h0) begin err_n++; $display("FAIL reset_pc: got %h want 0", s_pc); end
    cmp_n++; if (s_instr !== 32'h0) begin err_n++; $display("FAIL reset_instr: got %h want 0", s_instr); end
  endtask

  task automatic test_stream();
    reset = 1'b1; if_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      cmp_n++;
      if (s_gnt_hs !== 1'b1 || s_iaddr !== 32'(4 * k)) begin
        err_n++; $display("FAIL stream_iaddr[%0d]: got hs=%b %h want hs=1 %h", k, s_gnt_hs, s_iaddr, 32'(4 * k));
      end
      cmp_n++;
      if (s_valid !== (k >= 2)) begin
        err_n++; $display("FAIL stream_valid[%0d]: got %b want %b", k, s_valid, (k >= 2));
      end
      if (k >= 2) begin
        cmp_n++;
        if (s_pc !== 32'(4 * (k - 2)) || s_instr !== memw(32'(4 * (k - 2)))) begin
          err_n++; $display("FAIL stream_out[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                            k, s_pc, s_instr, 32'(4 * (k - 2)), memw(32'(4 * (k - 2))));
        end
      end
    end
  endtask

  task automatic test_fill();
    int n = 0;
    int got = 0;
    bit seen = 1'b0;
    logic [31:0] first = '0;
    if_ready = 1'b0;
    do_reset();
    for (int t = 0; t < 12; t++) begin
      tick();
      if (s_gnt_hs) n++;
    end
    cmp_n++; if (n != DEPTH) begin err_n++; $display("FAIL fill_grants: got %0d want %0d", n, DEPTH); end
    cmp_n++; if (s_req !== 1'b0) begin err_n++; $display("FAIL fill_req: got %b want 0", s_req); end
    if_ready = 1'b1;
    for (int t = 0; t < 20 && got < 4; t++) begin
      tick();
      if (s_gnt_hs && !seen) begin seen = 1'b1; first = s_iaddr; end
      if (s_hs) begin
        cmp_n++;
        if (s_pc !== 32'(4 * got) || s_instr !== memw(32'(4 * got))) begin
          err_n++; $display("FAIL fill_drain[%0d]: got pc=%h instr=%h want pc=%h", got, s_pc, s_instr, 32'(4 * got));
        end
        got++;
      end
    end
    cmp_n++; if (got != 4) begin err_n++; $display("FAIL fill_drain_cnt: got %0d want 4", got); end
    cmp_n++;
    if (!seen || first !== 32'h10) begin
      err_n++; $display("FAIL fill_resume: got seen=%b addr=%h want addr=00000010", seen, first);
    end
  endtask

  task automatic wait_first_hs(input string name, input logic [31:0] want_pc);
    bit done = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      tick();
      if (s_hs) begin
        done = 1'b1;
        cmp_n++;
        if (s_pc !== want_pc || s_instr !== memw(want_pc)) begin
          err_n++; $display("FAIL %s: got pc=%h instr=%h want pc=%h instr=%h",
                            name, s_pc, s_instr, want_pc, memw(want_pc));
        end
      end
    end
    cmp_n++; if (!done) begin err_n++; $display("FAIL %s_timeout: got no handshake want one", name); end
  endtask

  task automatic test_redirect();
    bit seen = 1'b0;
    logic [31:0] a0, a1;
    if_ready = 1'b0; rsp_en = 1'b1;
    do_reset();
    rsp_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h20; tick(); redirect_valid = 1'b0;
    cmp_n++; if (s_req !== 1'b0) begin err_n++; $display("FAIL redir_req: got %b want 0", s_req); end
    tick(); a0 = s_iaddr;
    tick(); a1 = s_iaddr;
    cmp_n++;
    if (a0 !== 32'h20 || a1 !== 32'h24) begin
      err_n++; $display("FAIL redir_setup: got %h,%h want 00000020,00000024", a0, a1);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100; tick(); redirect_valid = 1'b0;
    rsp_en = 1'b1; if_ready = 1'b1;
    tick();
    cmp_n++;
    if (s_gnt_hs !== 1'b1 || s_iaddr !== 32'h100) begin
      err_n++; $display("FAIL redir_fetch: got hs=%b %h want hs=1 00000100", s_gnt_hs, s_iaddr);
    end
    seen = s_hs;
    cmp_n++; if (seen !== 1'b0) begin err_n++; $display("FAIL redir_early: got valid handshake want none"); end
    wait_first_hs("redir_first", 32'h100);
  endtask

  task automatic test_back_to_back();
    if_ready = 1'b0; rsp_en = 1'b1;
    do_reset();
    rsp_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200; tick(); redirect_valid = 1'b0;
    repeat (3) tick();
    cmp_n++; if (pend_q.size() != 3) begin err_n++; $display("FAIL b2b_setup: got %0d want 3 in flight", pend_q.size()); end
    rsp_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h300; tick();
    cmp_n++; if (s_req !== 1'b0) begin err_n++; $display("FAIL b2b_req0: got %b want 0", s_req); end
    redirect_pc = 32'h400; tick();
    cmp_n++; if (s_req !== 1'b0) begin err_n++; $display("FAIL b2b_req1: got %b want 0", s_req); end
    redirect_valid = 1'b0; if_ready = 1'b1;
    wait_first_hs("b2b_first", 32'h400);
  endtask

  task automatic test_reset_full();
    if_ready = 1'b0; rsp_en = 1'b1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h40; tick(); redirect_valid = 1'b0;
    repeat (10) tick();
    cmp_n++; if (s_valid !== 1'b1 || s_pc !== 32'h40) begin err_n++; $display("FAIL rstf_full: got v=%b pc=%h want v=1 pc=00000040", s_valid, s_pc); end
    reset = 1'b0; tick();
    cmp_n++; if (s_valid !== 1'b0) begin err_n++; $display("FAIL rstf_valid0: got %b want 0", s_valid); end
    cmp_n++; if (s_iaddr !== 32'h0 || s_req !== 1'b0) begin err_n++; $display("FAIL rstf_iaddr: got req=%b %h want req=0 00000000", s_req, s_iaddr); end
    reset = 1'b1; inject_junk = 1'b1; tick(); inject_junk = 1'b0;
    cmp_n++; if (s_valid !== 1'b0) begin err_n++; $display("FAIL rstf_valid1: got %b want 0", s_valid); end
    cmp_n++; if (s_gnt_hs !== 1'b1 || s_iaddr !== 32'h0) begin err_n++; $display("FAIL rstf_restart: got hs=%b %h want hs=1 00000000", s_gnt_hs, s_iaddr); end
    if_ready = 1'b1;
    wait_first_hs("rstf_first", 32'h0);
  endtask

  task automatic test_align();
    int got = 0;
    logic [31:0] want;
    if_ready = 1'b1; rsp_en = 1'b1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h103; tick(); redirect_valid = 1'b0;
    tick();
    cmp_n++; if (s_gnt_hs !== 1'b1 || s_iaddr !== 32'h100) begin err_n++; $display("FAIL align_iaddr: got %h want 00000100", s_iaddr); end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 1'b0;
    tick();
    cmp_n++; if (s_iaddr !== 32'hFFFF_FFFC) begin err_n++; $display("FAIL wrap_iaddr0: got %h want fffffffc", s_iaddr); end
    tick();
    cmp_n++; if (s_iaddr !== 32'h0) begin err_n++; $display("FAIL wrap_iaddr1: got %h want 00000000", s_iaddr); end
    want = 32'hFFFF_FFFC;
    for (int t = 0; t < 20 && got < 2; t++) begin
      if (t > 0) tick();
      if (s_hs) begin
        cmp_n++;
        if (s_pc !== want || s_instr !== memw(want)) begin
          err_n++; $display("FAIL wrap_pc[%0d]: got pc=%h instr=%h want pc=%h", got, s_pc, s_instr, want);
        end
        want = want + 32'd4;
        got++;
      end
    end
    cmp_n++; if (got != 2) begin err_n++; $display("FAIL wrap_cnt: got %0d want 2", got); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_fetch;
    int nhs = 0;
    gnt_pct = 70; rv_pct = 70; max_lat = 3; rsp_en = 1'b1;
    do_reset();
    exp_pc = 32'h0; exp_fetch = 32'h0;
    for (int t = 0; t < 2000; t++) begin
      if_ready       = ($urandom_range(0, 99) < 60);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = $urandom;
      tick();
      if (redirect_valid) begin
        cmp_n++; if (s_req !== 1'b0) begin err_n++; $display("FAIL rnd_redir_req[%0d]: got %b want 0", t, s_req); end
        exp_pc    = {redirect_pc[31:2], 2'b00};
        exp_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        if (s_gnt_hs) begin
          cmp_n++;
          if (s_iaddr !== exp_fetch) begin err_n++; $display("FAIL rnd_iaddr[%0d]: got %h want %h", t, s_iaddr, exp_fetch); end
          exp_fetch = exp_fetch + 32'd4;
        end
        if (s_hs) begin
          cmp_n++;
          if (s_pc !== exp_pc || s_instr !== memw(exp_pc)) begin
            err_n++; $display("FAIL rnd_out[%0d]: got pc=%h instr=%h want pc=%h instr=%h", t, s_pc, s_instr, exp_pc, memw(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
          nhs++;
        end
      end
      cmp_n++;
      if (pend_q.size() > DEPTH) begin err_n++; $display("FAIL rnd_inflight[%0d]: got %0d want <= %0d", t, pend_q.size(), DEPTH); end
    end
    redirect_valid = 1'b0;
    cmp_n++; if (nhs < 200) begin err_n++; $display("FAIL rnd_progress: got %0d handshakes want >= 200", nhs); end
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf();
    gnt_pct = 0; rv_pct = 100; max_lat = 1; rsp_en = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
    do_reset();
    repeat (5) tick();
    gnt_pct = 100;
    repeat (3) tick();
    cmp_n++; if (s_valid !== 1'b1) begin err_n++; $display("FAIL perf_valid: got %b want 1", s_valid); end
    cmp_n++; if (fetch_stall_cnt !== 32'd7) begin err_n++; $display("FAIL perf_stall: got %0d want 7", fetch_stall_cnt); end
    redirect_valid = 1'b1; redirect_pc = 32'h80; tick(); redirect_valid = 1'b0;
    cmp_n++; if (flush_cnt !== 32'd1) begin err_n++; $display("FAIL perf_flush: got %0d want 1", flush_cnt); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; idata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_back_to_back();
    test_reset_full();
    test_align();
    test_random();
`ifdef IFU_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
`default_nettype wire
